// File: rtl/cu_pkg.sv
// Shared micro-sequencer definitions: states, opcodes, control-bus bit map.
// CU_SEQUENCER_SINGLE_STEP_EN adds the STEP_WAIT state.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_DECODE,
    S_EXEC0,
    S_EXEC1,
    S_EXEC2,
    S_WB,
    S_HALT
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_e;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_OR    = 8'h06;
  localparam logic [7:0] OP_JMP   = 8'h07;
  localparam logic [7:0] OP_JZ    = 8'h08;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam int CS_PC_INC       = 0;
  localparam int CS_PC_LOAD      = 1;
  localparam int CS_MAR_FROM_PC  = 2;
  localparam int CS_MAR_FROM_IR  = 3;
  localparam int CS_MEM_READ     = 4;
  localparam int CS_MEM_WRITE    = 5;
  localparam int CS_MBR_TO_IR    = 6;
  localparam int CS_MBR_TO_BR    = 7;
  localparam int CS_ACC_CLEAR    = 8;
  localparam int CS_ACC_FROM_OFR = 9;
  localparam int CS_OFR_LOAD     = 12;
  localparam int CS_ALU_OP_LSB   = 13;
  localparam int CS_ALU_OP_MSB   = 15;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;

  function automatic logic op_legal(input logic [7:0] op);
    return (op <= OP_JZ) || (op == OP_HALT);
  endfunction

  // Opcodes that need the memory operand phases (EXEC0 onward)
  function automatic logic op_has_exec(input logic [7:0] op);
    return (op >= OP_LOAD) && (op <= OP_OR);
  endfunction

  function automatic logic [2:0] alu_sel(input logic [7:0] op);
    logic [2:0] r;
    unique case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      default: r = ALU_PASS_B;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Sequencer <-> datapath bundle; master is the sequencer side.
// step exists only with CU_SEQUENCER_SINGLE_STEP_EN.
interface cu_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [7:0]       ir_opcode;
  logic             acc_zero;
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
  logic             step;
`endif
  logic [31:0]      control_signal;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, ir_opcode, acc_zero,
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
    input  step,
`endif
    output control_signal, busy, halted,
    output illegal, instr_count
  );

  modport slave (
    output start, ir_opcode, acc_zero,
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
    output step,
`endif
    input  control_signal, busy, halted,
    input  illegal, instr_count
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational state + opcode -> control_signal mapper.
module cu_decode
  import cu_pkg::*;
(
  input  state_e      state_i,
  input  logic [7:0]  opcode_i,
  input  logic        acc_zero_i,
  output logic [31:0] control_signal_o,
  output logic        illegal_o
);

  always_comb begin
    control_signal_o = '0;
    illegal_o        = 1'b0;
    unique case (state_i)
      S_FETCH0: begin
        control_signal_o[CS_MAR_FROM_PC] = 1'b1;
        control_signal_o[CS_MEM_READ]    = 1'b1;
      end
      S_FETCH1: begin
        control_signal_o[CS_MBR_TO_IR] = 1'b1;
        control_signal_o[CS_PC_INC]    = 1'b1;
      end
      S_DECODE: begin
        illegal_o = !op_legal(opcode_i);
        if (opcode_i == OP_JMP)
          control_signal_o[CS_PC_LOAD] = 1'b1;
        if (opcode_i == OP_JZ)
          control_signal_o[CS_PC_LOAD] = acc_zero_i;
      end
      S_EXEC0: begin
        control_signal_o[CS_MAR_FROM_IR] = 1'b1;
        control_signal_o[CS_MEM_READ] =
          (opcode_i != OP_STORE);
      end
      S_EXEC1: begin
        if (opcode_i == OP_STORE)
          control_signal_o[CS_MEM_WRITE] = 1'b1;
        else
          control_signal_o[CS_MBR_TO_BR] = 1'b1;
      end
      S_EXEC2: begin
        control_signal_o[CS_OFR_LOAD] = 1'b1;
        control_signal_o[CS_ALU_OP_MSB:CS_ALU_OP_LSB] =
          alu_sel(opcode_i);
      end
      S_WB: begin
        control_signal_o[CS_ACC_FROM_OFR] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Hardwired fetch/decode/execute micro-sequencer driving control_signal.
// CU_SEQUENCER_SINGLE_STEP_EN parks in STEP_WAIT between instructions.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  cu_sequencer_if.master bus
);

`ifdef CU_SEQUENCER_SINGLE_STEP_EN
  localparam state_e S_NEXT = S_STEP_WAIT;
`else
  localparam state_e S_NEXT = S_FETCH0;
`endif

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // The opcode is taken live in DECODE and held for the exec phases
  assign op_d = (state_q == S_DECODE) ? bus.ir_opcode : op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_DECODE;
      S_DECODE: begin
        if (op_d == OP_HALT) begin
          state_d = S_HALT;
        end else if (op_has_exec(op_d)) begin
          state_d = S_EXEC0;
        end else begin
          retire  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_EXEC0: state_d = S_EXEC1;
      S_EXEC1: begin
        if (op_q == OP_STORE) begin
          retire  = 1'b1;
          state_d = S_NEXT;
        end else begin
          state_d = S_EXEC2;
        end
      end
      S_EXEC2: state_d = S_WB;
      S_WB: begin
        retire  = 1'b1;
        state_d = S_NEXT;
      end
      S_HALT: state_d = S_HALT;
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
      S_STEP_WAIT: if (bus.step) state_d = S_FETCH0;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = retire
    ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}
    : cnt_q;

  cu_decode u_decode (
    .state_i          (state_q),
    .opcode_i         (op_d),
    .acc_zero_i       (bus.acc_zero),
    .control_signal_o (bus.control_signal),
    .illegal_o        (bus.illegal)
  );

  assign bus.busy =
    (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Randomised bench for cu_sequencer against an instruction-level model.
// Build with CU_SEQUENCER_SINGLE_STEP_EN to exercise STEP_WAIT.
module tb_cu_sequencer;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cu_sequencer_if #(.CNT_W(16)) bus ();

  cu_sequencer #(.CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk;
  int          n_fail;
  int          ill_seen;
  logic        exp_valid;
  logic [31:0] exp_cs;
  logic        exp_busy;
  logic        exp_halt;
  logic        exp_ill;
  logic [15:0] exp_cnt;
  logic [15:0] m_cnt;
  logic        m_halt;
  logic [31:0] seen_cs;
  logic [15:0] seen_cnt;
  logic        seen_busy;
  logic        seen_halt;
  logic [31:0] trace[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, want, $time);
    end
  endtask

  function automatic logic legal_m(input logic [7:0] op);
    return (op <= 8'h08) || (op == 8'hFF);
  endfunction

  function automatic int ilen(input logic [7:0] op);
    if (op == 8'h02) return 5;
    if (op >= 8'h01 && op <= 8'h06) return 7;
    return 3;
  endfunction

  // Expected control word for cycle k of an instruction
  function automatic logic [31:0] mword(input logic [7:0] op,
                                        input int k,
                                        input logic az);
    logic [31:0] alu;
    alu = (op == 8'h01) ? 32'd0 : 32'(op) - 32'd2;
    case (k)
      0: return 32'h14;
      1: return 32'h41;
      2: begin
        if (op == 8'h07) return 32'h2;
        if (op == 8'h08) return az ? 32'h2 : 32'h0;
        return 32'h0;
      end
      3: return (op == 8'h02) ? 32'h08 : 32'h18;
      4: return (op == 8'h02) ? 32'h20 : 32'h80;
      5: return 32'h1000 | (alu << 13);
      default: return 32'h200;
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      check("control_signal", bus.control_signal, exp_cs);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("halted", 32'(bus.halted), 32'(exp_halt));
      check("illegal", 32'(bus.illegal), 32'(exp_ill));
      check("instr_count", 32'(bus.instr_count),
            32'(exp_cnt));
    end
  end

  task automatic cyc(input logic st, input logic az,
                     input logic [7:0] op, input logic stp,
                     input logic r);
    bus.start     = st;
    bus.acc_zero  = az;
    bus.ir_opcode = op;
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
    bus.step      = stp;
`endif
    rst = r;
    @(negedge clk);
    seen_cs   = bus.control_signal;
    seen_cnt  = bus.instr_count;
    seen_busy = bus.busy;
    seen_halt = bus.halted;
    if (bus.illegal) ill_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rest();
    exp_cs   = 32'h0;
    exp_busy = 1'b0;
    exp_halt = m_halt;
    exp_ill  = 1'b0;
    exp_cnt  = m_cnt;
  endtask

  task automatic run_instr(input logic [7:0] op,
                           input int azm,
                           input int abort_k);
    int   n;
    logic az;
    logic r;
    trace.delete();
    n = ilen(op);
    for (int k = 0; k < n; k++) begin
      az = (azm == 2) ? 1'($urandom) : 1'(azm);
      exp_cs   = mword(op, k, az);
      exp_busy = 1'b1;
      exp_halt = 1'b0;
      exp_ill  = (k == 2) && !legal_m(op);
      exp_cnt  = m_cnt;
      r = (k == abort_k);
      cyc(1'($urandom), az,
          (k == 2) ? op : 8'($urandom),
          1'($urandom), r);
      trace.push_back(seen_cs);
      if (r) begin
        m_cnt  = 16'd0;
        m_halt = 1'b0;
        return;
      end
    end
    if (op == 8'hFF) begin
      m_halt = 1'b1;
    end else begin
      m_cnt = m_cnt + 16'd1;
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
      n = $urandom_range(0, 2);
      for (int w = 0; w <= n; w++) begin
        exp_cs   = 32'h0;
        exp_busy = 1'b1;
        exp_halt = 1'b0;
        exp_ill  = 1'b0;
        exp_cnt  = m_cnt;
        cyc(1'($urandom), 1'($urandom), 8'($urandom),
            (w == n), 1'b0);
      end
`endif
    end
  endtask

  initial begin
    logic [31:0] add_ref[7];
    int          r;
    logic [7:0]  op;
    add_ref = '{32'h14, 32'h41, 32'h0, 32'h18,
                32'h80, 32'h3000, 32'h200};
    n_chk     = 0;
    n_fail    = 0;
    ill_seen  = 0;
    exp_valid = 1'b0;
    m_cnt     = 16'd0;
    m_halt    = 1'b0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.ir_opcode = 8'h00;
    bus.acc_zero  = 1'b0;
`ifdef CU_SEQUENCER_SINGLE_STEP_EN
    bus.step      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    exp_valid = 1'b1;

    set_rest();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_cs", seen_cs, 32'h0);
    check("rst_busy", 32'(seen_busy), 32'h0);
    check("rst_cnt", 32'(seen_cnt), 32'h0);

    set_rest();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    run_instr(8'h03, 2, -1);
    check("add_len", 32'(trace.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < trace.size())
        check("add_word", trace[i], add_ref[i]);
    check("add_cnt", 32'(bus.instr_count), 32'd1);

    run_instr(8'h08, 0, -1);
    check("jz0_len", 32'(trace.size()), 32'd3);
    check("jz0_dec", trace[2], 32'h0);
    run_instr(8'h08, 1, -1);
    check("jz1_len", 32'(trace.size()), 32'd3);
    check("jz1_dec", trace[2], 32'h2);

    ill_seen = 0;
    run_instr(8'h42, 2, -1);
    check("ill_pulses", 32'(ill_seen), 32'd1);
    check("ill_len", 32'(trace.size()), 32'd3);
    check("ill_cnt", 32'(bus.instr_count), 32'd4);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 8) op = 8'(r);
      else if (r <= 10) op = 8'($urandom_range(9, 254));
      else op = 8'h00;
      run_instr(op, 2, -1);
    end

    run_instr(8'h03, 2, 5);
    check("abort_len", 32'(trace.size()), 32'd6);
    for (int i = 0; i < 3; i++) begin
      set_rest();
      cyc(1'b0, 1'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    check("abort_cnt", 32'(seen_cnt), 32'h0);
    check("abort_cs", seen_cs, 32'h0);

    set_rest();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    run_instr(8'h01, 2, -1);
    check("load_len", 32'(trace.size()), 32'd7);
    run_instr(8'h02, 2, -1);
    check("store_len", 32'(trace.size()), 32'd5);
    run_instr(8'hFF, 2, -1);
    check("halt_len", 32'(trace.size()), 32'd3);
    for (int i = 0; i < 4; i++) begin
      set_rest();
      cyc(1'b1, 1'($urandom), 8'($urandom), 1'b1, 1'b0);
    end
    check("halt_flag", 32'(seen_halt), 32'h1);
    check("halt_busy", 32'(seen_busy), 32'h0);
    check("halt_cnt", 32'(seen_cnt), 32'd2);

`ifdef CU_SEQUENCER_SINGLE_STEP_EN
    set_rest();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    m_halt = 1'b0;
    m_cnt  = 16'd0;
    set_rest();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_instr(8'h00, 2, -1);
      check("step_nop_len", 32'(trace.size()), 32'd3);
    end
    check("step_cnt", 32'(bus.instr_count), 32'd4);
`endif

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
